// File: rtl/line_decoder.sv
// ---------------------------------------------------------------------------
// line_decoder
//
// Receive side of the character-row serial line. The line is oversampled on
// sample_clk. Each bit period it is either steady high (QUIET) or toggling at
// the roll-clock rate (ACTIVE). Each bit window is classified by how many
// edges it contains. The decoded bits are shifted into a row word, MSB first.
// A QUIET window that closes with the line low is flagged as a stuck-low line.
//
// Ports
//   sample_clk  in         oversampling clock
//   reset_p     in         synchronous active-high reset
//   idata       in         serial line, asynchronous to sample_clk
//   start       in         one-cycle pulse aligned to the first bit period of a row
//   row_data    out [127:0] decoded row; bit COL_CNT-1 is the first bit received
//   row_valid   out        one-cycle pulse when row_data is updated
//   busy        out        high while a row is being received (RUN and DONE)
//   line_err    out        sticky stuck-low flag, cleared by start or reset
// ---------------------------------------------------------------------------
module line_decoder #(
    parameter logic [15:0] COL_CNT    = 16'd80,  // 1..128
    parameter logic        TURN       = 1'b1,    // 1: ACTIVE->0, QUIET->1
    parameter logic [15:0] BIT_CYCLES = 16'd32,  // >= 4
    parameter logic [7:0]  EDGE_MIN   = 8'd2     // >= 1
) (
    input  logic         sample_clk,
    input  logic         reset_p,
    input  logic         idata,
    input  logic         start,
    output logic [127:0] row_data,
    output logic         row_valid,
    output logic         busy,
    output logic         line_err
);

    localparam logic [15:0]  LastCyc = BIT_CYCLES - 16'd1;
    localparam logic [7:0]   LastBit = COL_CNT[7:0] - 8'd1;
    // Keeps only the low COL_CNT bits; COL_CNT=128 shifts by zero (all ones).
    localparam logic [127:0] ColMask = {128{1'b1}} >> (16'd128 - COL_CNT);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q;
    logic           sync1_q, sync2_q, dly_q;
    logic [15:0]    cyc_cnt_q;
    logic [7:0]     bit_cnt_q;
    logic [7:0]     edge_cnt_q;
    logic [127:0]   shreg_q;
    logic [127:0]   row_data_q;
    logic           row_valid_q;
    logic           busy_q;
    logic           line_err_q;

    logic           edge_det;
    logic           win_close;
    logic [7:0]     edge_sum;
    logic           win_active;
    logic           bit_dec;
    logic [127:0]   shreg_nxt;

    // Window classification; edge_sum includes the edge seen in the closing cycle.
    always_comb begin
        edge_det   = sync2_q ^ dly_q;
        win_close  = (state_q == StRun) && (cyc_cnt_q == LastCyc);
        edge_sum   = (edge_cnt_q == 8'hFF) ? 8'hFF : edge_cnt_q + {7'd0, edge_det};
        win_active = (edge_sum >= EDGE_MIN);
        bit_dec    = win_active ^ TURN;
        shreg_nxt  = {shreg_q[126:0], bit_dec};
    end

    always_ff @(posedge sample_clk) begin
        if (reset_p) begin
            // Line idles high, so the synchronizer and delay flop start at 1
            // to avoid a false edge on the first samples.
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            dly_q       <= 1'b1;
            state_q     <= StIdle;
            cyc_cnt_q   <= 16'd0;
            bit_cnt_q   <= 8'd0;
            edge_cnt_q  <= 8'd0;
            shreg_q     <= '0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            line_err_q  <= 1'b0;
        end else begin
            sync1_q     <= idata;
            sync2_q     <= sync1_q;
            dly_q       <= sync2_q;
            row_valid_q <= 1'b0;

            if (start) begin
                // Start from any state (re)begins the row at window 0; an
                // aborted row never pulses row_valid and leaves row_data alone.
                state_q    <= StRun;
                cyc_cnt_q  <= 16'd0;
                bit_cnt_q  <= 8'd0;
                edge_cnt_q <= 8'd0;
                shreg_q    <= '0;
                line_err_q <= 1'b0;
                busy_q     <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        busy_q <= 1'b0;
                    end
                    StRun: begin
                        if (win_close) begin
                            cyc_cnt_q  <= 16'd0;
                            edge_cnt_q <= 8'd0;
                            bit_cnt_q  <= bit_cnt_q + 8'd1;
                            shreg_q    <= shreg_nxt;
                            if (!win_active && !sync2_q) begin
                                line_err_q <= 1'b1;
                            end
                            if (bit_cnt_q == LastBit) begin
                                // Outputs are registered, so they show up in
                                // the single DONE cycle.
                                state_q     <= StDone;
                                row_data_q  <= shreg_nxt & ColMask;
                                row_valid_q <= 1'b1;
                            end
                        end else begin
                            cyc_cnt_q  <= cyc_cnt_q + 16'd1;
                            edge_cnt_q <= edge_sum;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign row_data  = row_data_q;
    assign row_valid = row_valid_q;
    assign busy      = busy_q;
    assign line_err  = line_err_q;

endmodule

// File: tb/tb_line_decoder.sv
// ---------------------------------------------------------------------------
// tb_line_decoder
//
// Directed bench for line_decoder. Four instances cover the parameter sets
// needed (80-bit TURN=1, 8-bit TURN=0, 8-bit TURN=1, 4-bit TURN=1). They share
// the clock, reset and serial line; each has its own start.
//
// Stimulus iteration j: wait for posedge, sample outputs #1 later, then drive
// idata/start. start is driven at j=1. With the 2-flop synchronizer, window k
// of the decoder sees the idata driven at j = k*BC .. k*BC+BC-1.
// ---------------------------------------------------------------------------
module tb_line_decoder;

    localparam int BC = 32;

    logic clk = 1'b0;
    logic reset_p;
    logic idata;
    logic [3:0] start_v;

    logic [127:0] rd [4];
    logic         rv [4];
    logic         bz [4];
    logic         le [4];

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;
    int wtype [128];  // 0 steady high, 1 toggling, 2 stuck low, 3 low in last cycle

    logic [127:0] s_rd;
    logic         s_rv, s_bz, s_le;

    always #5 clk = ~clk;

    line_decoder #(.COL_CNT(16'd80), .TURN(1'b1), .BIT_CYCLES(16'd32), .EDGE_MIN(8'd2)) u80 (
        .sample_clk(clk), .reset_p(reset_p), .idata(idata), .start(start_v[0]),
        .row_data(rd[0]), .row_valid(rv[0]), .busy(bz[0]), .line_err(le[0])
    );
    line_decoder #(.COL_CNT(16'd8), .TURN(1'b0), .BIT_CYCLES(16'd32), .EDGE_MIN(8'd2)) u8a (
        .sample_clk(clk), .reset_p(reset_p), .idata(idata), .start(start_v[1]),
        .row_data(rd[1]), .row_valid(rv[1]), .busy(bz[1]), .line_err(le[1])
    );
    line_decoder #(.COL_CNT(16'd8), .TURN(1'b1), .BIT_CYCLES(16'd32), .EDGE_MIN(8'd2)) u8b (
        .sample_clk(clk), .reset_p(reset_p), .idata(idata), .start(start_v[2]),
        .row_data(rd[2]), .row_valid(rv[2]), .busy(bz[2]), .line_err(le[2])
    );
    line_decoder #(.COL_CNT(16'd4), .TURN(1'b1), .BIT_CYCLES(16'd32), .EDGE_MIN(8'd2)) u4 (
        .sample_clk(clk), .reset_p(reset_p), .idata(idata), .start(start_v[3]),
        .row_data(rd[3]), .row_valid(rv[3]), .busy(bz[3]), .line_err(le[3])
    );

    always_comb begin
        s_rd = rd[0];
        s_rv = rv[0];
        s_bz = bz[0];
        s_le = le[0];
        case (cur)
            1: begin s_rd = rd[1]; s_rv = rv[1]; s_bz = bz[1]; s_le = le[1]; end
            2: begin s_rd = rd[2]; s_rv = rv[2]; s_bz = bz[2]; s_le = le[2]; end
            3: begin s_rd = rd[3]; s_rv = rv[3]; s_bz = bz[3]; s_le = le[3]; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line_level(input int j, input int nwin);
        int k;
        int s;
        k = j / BC;
        s = j % BC;
        if (k >= nwin) return 1'b1;
        case (wtype[k])
            1:       return ((s / 4) % 2 == 0) ? 1'b0 : 1'b1;  // roll period 8 cycles
            2:       return 1'b0;
            3:       return (s == BC - 1) ? 1'b0 : 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    // Bit b maps to ACTIVE when b ^ turn is 1.
    task automatic set_row(input logic [127:0] row, input int ncol, input logic turn);
        logic b;
        for (int k = 0; k < 128; k++) wtype[k] = 0;
        for (int k = 0; k < ncol; k++) begin
            b = row[ncol - 1 - k];
            wtype[k] = (b ^ turn) ? 1 : 0;
        end
    endtask

    task automatic run_row(input int sel, input int nwin, input int j_from, input int j_to,
                           output int rv_cnt, output int rv_at, output int busy_cyc);
        cur      = sel;
        rv_cnt   = 0;
        rv_at    = -1;
        busy_cyc = 0;
        for (int j = j_from; j <= j_to; j++) begin
            @(posedge clk);
            #1;
            if (s_rv) begin
                rv_cnt++;
                rv_at = j;
            end
            if (s_bz) busy_cyc++;
            idata   = line_level(j, nwin);
            start_v = (j == 1) ? (4'b0001 << sel) : 4'b0000;
        end
    endtask

    int rvc, rva, bzc;

    initial begin
        reset_p = 1'b1;
        idata   = 1'b1;
        start_v = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_row_data", rd[0], 128'd0);
        check("reset_row_valid", {127'd0, rv[0]}, 128'd0);
        check("reset_busy", {127'd0, bz[0]}, 128'd0);
        check("reset_line_err", {127'd0, le[0]}, 128'd0);
        reset_p = 1'b0;

        // 1: 80-bit F0F0 row, TURN=1
        set_row({48'd0, 80'hF0F0_F0F0_F0F0_F0F0_F0F0}, 80, 1'b1);
        run_row(0, 80, 0, 2565, rvc, rva, bzc);
        check("t1_rv_count", rvc, 1);
        check("t1_rv_time", rva, 2 + 80 * BC);
        check("t1_row_data", s_rd, {48'd0, 80'hF0F0_F0F0_F0F0_F0F0_F0F0});
        check("t1_line_err", {127'd0, s_le}, 128'd0);

        // 2: TURN=0, 8-bit A5, toggling windows carry 8 edges
        set_row(128'hA5, 8, 1'b0);
        run_row(1, 8, 0, 262, rvc, rva, bzc);
        check("t2_row_data", s_rd, 128'hA5);
        check("t2_busy_cycles", bzc, 257);
        check("t2_rv_time", rva, 2 + 8 * BC);

        // 3: one edge in window 2 (low in its closing cycle) is QUIET; closing
        //    low also marks the line stuck-low
        for (int k = 0; k < 128; k++) wtype[k] = 0;
        wtype[2] = 3;
        run_row(3, 4, 0, 2 + 4 * BC + 3, rvc, rva, bzc);
        check("t3_row_data", s_rd, 128'hF);
        check("t3_rv_count", rvc, 1);
        check("t3_line_err", {127'd0, s_le}, 128'd1);

        // 4: window 5 of 8 held low
        for (int k = 0; k < 128; k++) wtype[k] = 0;
        wtype[5] = 2;
        run_row(2, 8, 0, 1 + 6 * BC, rvc, rva, bzc);
        check("t4_err_before_close", {127'd0, s_le}, 128'd0);
        run_row(2, 8, 2 + 6 * BC, 2 + 8 * BC + 2, rvc, rva, bzc);
        check("t4_err_after_close", {127'd0, s_le}, 128'd1);
        check("t4_row_data", s_rd, 128'hFF);
        check("t4_rv_count", rvc, 1);
        for (int k = 0; k < 128; k++) wtype[k] = 0;
        run_row(2, 8, 0, 2, rvc, rva, bzc);
        check("t4_err_cleared", {127'd0, s_le}, 128'd0);

        // 5: 80-bit row restarted at window 40; first row has stuck-low windows
        for (int k = 0; k < 128; k++) wtype[k] = 2;
        run_row(0, 80, 0, 1 + 40 * BC, rvc, rva, bzc);
        check("t5_no_rv_first", rvc, 0);
        check("t5_err_first", {127'd0, s_le}, 128'd1);
        check("t5_data_kept", s_rd, {48'd0, 80'hF0F0_F0F0_F0F0_F0F0_F0F0});
        set_row({48'd0, 80'h1234_5678_9ABC_DEF0_0FF0}, 80, 1'b1);
        run_row(0, 80, 0, 2565, rvc, rva, bzc);
        check("t5_rv_count", rvc, 1);
        check("t5_rv_time", rva, 2 + 80 * BC);
        check("t5_row_data", s_rd, {48'd0, 80'h1234_5678_9ABC_DEF0_0FF0});
        check("t5_err_cleared", {127'd0, s_le}, 128'd0);

        // 6: reset together with start mid-row
        set_row({48'd0, 80'hAAAA_5555_C3C3_0000_FFFF}, 80, 1'b1);
        run_row(0, 80, 0, 1 + 20 * BC, rvc, rva, bzc);
        reset_p = 1'b1;
        start_v = 4'b0001;
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        start_v = 4'b0000;
        check("t6_rst_row_data", rd[0], 128'd0);
        check("t6_rst_row_valid", {127'd0, rv[0]}, 128'd0);
        check("t6_rst_busy", {127'd0, bz[0]}, 128'd0);
        check("t6_rst_line_err", {127'd0, le[0]}, 128'd0);
        @(posedge clk);
        #1;
        check("t6_idle_busy", {127'd0, bz[0]}, 128'd0);
        run_row(0, 80, 0, 2565, rvc, rva, bzc);
        check("t6_rv_count", rvc, 1);
        check("t6_rv_time", rva, 2 + 80 * BC);
        check("t6_row_data", s_rd, {48'd0, 80'hAAAA_5555_C3C3_0000_FFFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
